io_ports: RTL and testbench

//  Board-side I/O stage in front of and behind the cpu. Conditions the raw slide switches for the cpu input port.
//  - Input path: 2-FF synchroniser, then debouncer, producing the cpu input word entrada.
//  - Output path: latches the cpu output word saida and drives the LEDs plus a hex digit on the 7-seg display.
//  - Replaces the direct SWI->entrada and saida->LED wiring in top.

---
 rtl/io_pkg.sv | 16 +
 rtl/sw_debounce.sv | 53 +++++
 rtl/io_ports.sv | 64 ++++++
 tb/tb_io_ports.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and 7-segment decoder for the board I/O stage
package io_pkg;

  localparam int DEBOUNCE_DEFAULT = 16;

  // Segment order {g,f,e,d,c,b,a}, active-high, indexed by hex digit
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
    return SEG_HEX[i_nib];
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - 2-FF synchroniser plus vector-wide debouncer with change pulse
module sw_debounce
  import io_pkg::*;
#(
  parameter int W      = 5,
  parameter int CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_stable,
  output logic         o_changed
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [W-1:0]  r_s1;
  logic [W-1:0]  r_s2;
  logic [W-1:0]  r_cand;
  logic [W-1:0]  r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_changed;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_cand    <= '0;
      r_stable  <= '0;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_changed <= 1'b0;
      // Any difference in any bit restarts the whole-vector count
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt < CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_stable  <= r_cand;
        r_changed <= (r_cand != r_stable);
      end
    end
  end

  assign o_stable  = r_stable;
  assign o_changed = r_changed;

endmodule

// File: rtl/io_ports.sv
// rtl/io_ports.sv - switch conditioning into the cpu and latched LED / 7-seg output port
module io_ports
  import io_pkg::*;
#(
  parameter int NBITS           = 8,
  parameter int NIO_BITS        = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic                cpu_ce,
  input  logic [NIO_BITS-1:0] swi_raw,
  input  logic                io_wr,
  input  logic [NBITS-1:0]    io_wdata,
  output logic [NBITS-1:0]    entrada,
  output logic                in_changed,
  output logic [NIO_BITS-1:0] led,
  output logic [6:0]          seg
);

  logic [NIO_BITS-1:0] w_stable;
  logic                w_changed;
  logic                w_unused_hi;

  logic [NBITS-1:0]    r_entrada;
  logic [NBITS-1:0]    r_out_q;
  logic [6:0]          r_seg;

  sw_debounce #(
    .W      (NIO_BITS),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk     (clk_2),
    .i_resetn  (reset),
    .i_raw     (swi_raw),
    .o_stable  (w_stable),
    .o_changed (w_changed)
  );

  // entrada only moves on cpu edges so the cpu sees one value per cycle
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      r_entrada <= '0;
      r_out_q   <= '0;
      r_seg     <= hex_to_seg(4'h0);
    end else begin
      if (cpu_ce) begin
        r_entrada <= NBITS'(w_stable);
      end
      if (cpu_ce && io_wr) begin
        r_out_q <= io_wdata;
      end
      r_seg <= hex_to_seg(r_out_q[3:0]);
    end
  end

  assign w_unused_hi = ^r_out_q;

  assign entrada    = r_entrada;
  assign in_changed = w_changed;
  assign led        = r_out_q[NIO_BITS-1:0];
  assign seg        = r_seg;

endmodule

// File: tb/tb_io_ports.sv
// tb/tb_io_ports.sv - randomized and directed self-checking bench for io_ports
module tb_io_ports;

  localparam int D = 16;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       cpu_ce;
  logic [4:0] swi_raw;
  logic       io_wr;
  logic [7:0] io_wdata;
  logic [7:0] entrada;
  logic       in_changed;
  logic [4:0] led;
  logic [6:0] seg;

  always #5 clk_2 = ~clk_2;

  io_ports #(
    .NBITS           (8),
    .NIO_BITS        (5),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .cpu_ce     (cpu_ce),
    .swi_raw    (swi_raw),
    .io_wr      (io_wr),
    .io_wdata   (io_wdata),
    .entrada    (entrada),
    .in_changed (in_changed),
    .led        (led),
    .seg        (seg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference: raw value sampled at every edge; samples at or before the last reset read as 0
  logic [4:0] samp [0:8191];
  int         e = 0;
  int         last_rst = 0;
  logic [4:0] m_stable = '0;
  logic       m_inch = 1'b0;
  logic [7:0] m_entrada = '0;
  logic [7:0] m_out = '0;
  logic [6:0] m_seg = 7'h3F;
  int         pulses = 0;

  function automatic logic [4:0] sample(input int k);
    if (k <= last_rst) return 5'd0;
    return samp[k];
  endfunction

  // A value is accepted once D+1 consecutive synchronised samples agree
  task automatic model_edge();
    logic [4:0] w;
    logic [4:0] old_stable;
    bit         ok;
    e++;
    samp[e] = swi_raw;
    if (!reset) begin
      last_rst  = e;
      m_stable  = '0;
      m_inch    = 1'b0;
      m_entrada = '0;
      m_out     = '0;
      m_seg     = 7'h3F;
    end else begin
      w  = sample(e - 2);
      ok = 1;
      for (int k = e - 2 - D; k < e - 2; k++) begin
        if (sample(k) != w) ok = 0;
      end
      old_stable = m_stable;
      m_inch     = 1'b0;
      if (ok) begin
        m_inch   = (w != m_stable);
        m_stable = w;
      end
      m_seg = seg_tab[m_out[3:0]];
      if (cpu_ce && io_wr) m_out = io_wdata;
      if (cpu_ce) m_entrada = {3'b000, old_stable};
    end
  endtask

  task automatic cyc(input logic rst, input logic ce, input logic wr,
                     input logic [4:0] sw, input logic [7:0] wd);
    reset    = rst;
    cpu_ce   = ce;
    io_wr    = wr;
    swi_raw  = sw;
    io_wdata = wd;
    @(posedge clk_2);
    model_edge();
    @(negedge clk_2);
    chk("entrada", {24'd0, entrada}, {24'd0, m_entrada});
    chk("in_changed", {31'd0, in_changed}, {31'd0, m_inch});
    chk("led", {27'd0, led}, {27'd0, m_out[4:0]});
    chk("seg", {25'd0, seg}, {25'd0, m_seg});
    if (in_changed) pulses++;
  endtask

  initial begin
    logic [4:0] r_sw;
    int         hold;
    reset = 1'b0; cpu_ce = 1'b0; io_wr = 1'b0; swi_raw = '0; io_wdata = '0;

    // Reset with switches all high
    cyc(0, 0, 0, 5'h1F, 8'h00);
    cyc(0, 1, 1, 5'h1F, 8'hFF);
    chk("rst_entrada", {24'd0, entrada}, 32'h0);
    chk("rst_led", {27'd0, led}, 32'h0);
    chk("rst_seg", {25'd0, seg}, 32'h3F);
    chk("rst_inch", {31'd0, in_changed}, 32'h0);

    // Glitch shorter than the debounce window
    pulses = 0;
    for (int i = 1; i <= 10; i++) cyc(1, (i % 4) == 0, 0, 5'h01, 8'h00);
    for (int i = 1; i <= 30; i++) cyc(1, (i % 4) == 0, 0, 5'h00, 8'h00);
    chk("glitch_pulses", pulses, 0);
    chk("glitch_entrada", {24'd0, entrada}, 32'h0);

    // Clean change: accepted on edge D+3
    pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(1, (i % 4) == 0, 0, 5'h0A, 8'h00);
      if (i == D + 2) chk("clean_early", {31'd0, in_changed}, 32'h0);
      if (i == D + 3) chk("clean_edge", {31'd0, in_changed}, 32'h1);
    end
    chk("clean_pulses", pulses, 1);
    chk("clean_entrada", {24'd0, entrada}, 32'h0A);

    // Output port write, with and without cpu_ce
    cyc(1, 1, 1, 5'h0A, 8'hB7);
    chk("wr_led", {27'd0, led}, 32'h17);
    cyc(1, 0, 0, 5'h0A, 8'h00);
    chk("wr_seg", {25'd0, seg}, 32'h07);
    cyc(1, 0, 1, 5'h0A, 8'h3C);
    chk("nowr_led", {27'd0, led}, 32'h17);
    cyc(1, 0, 0, 5'h0A, 8'h00);
    chk("nowr_seg", {25'd0, seg}, 32'h07);

    // Reset while a change is mid-debounce, then full re-debounce
    for (int i = 1; i <= 11; i++) cyc(1, 0, 0, 5'h13, 8'h00);
    cyc(0, 0, 0, 5'h13, 8'h00);
    chk("mid_entrada", {24'd0, entrada}, 32'h0);
    chk("mid_led", {27'd0, led}, 32'h0);
    chk("mid_seg", {25'd0, seg}, 32'h3F);
    pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(1, (i % 4) == 0, 0, 5'h13, 8'h00);
      if (i == D + 2) chk("redeb_early", {31'd0, in_changed}, 32'h0);
      if (i == D + 3) chk("redeb_edge", {31'd0, in_changed}, 32'h1);
    end
    chk("redeb_pulses", pulses, 1);
    chk("redeb_entrada", {24'd0, entrada}, 32'h13);

    // cpu_ce on the very edge stable updates
    for (int i = 1; i <= 24; i++) begin
      cyc(1, (i == D + 3) || (i == D + 6), 0, 5'h15, 8'h00);
      if (i == D + 3) chk("coin_old", {24'd0, entrada}, 32'h13);
      if (i == D + 6) chk("coin_new", {24'd0, entrada}, 32'h15);
    end

    // Random traffic against the reference
    hold = 0;
    r_sw = '0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        r_sw = 5'($urandom);
        hold = $urandom_range(1, 40);
      end
      hold--;
      cyc($urandom_range(0, 399) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, r_sw, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
